// File: rtl/quantium_wb_pkg.sv
// Shared types and helpers for the Wishbone load/store master.
//   lsu_size_t     : access size encoding on req_size (11 is illegal)
//   lsu_state_t    : bus master FSM states
//   CTI_CLASSIC    : cycle type identifier driven on every bus cycle
//   lsu_misaligned : 1 when a request must be refused without a bus cycle
package quantium_wb_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } lsu_size_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_GAP,
      ST_WRITE
   } lsu_state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;

   // Halfwords need an even address, words a 4-byte aligned one; size 11 never
   // names a legal access.
   function automatic logic lsu_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return addr_lo[0];
         SZ_W:    return (addr_lo != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering between the core and a 32-bit
// little-endian word bus.
//   addr_lo     in  2   byte offset of the access within the word
//   size        in  2   access size (SZ_B/SZ_H/SZ_W)
//   is_unsigned in  1   loads: 1 zero-extend, 0 sign-extend
//   bus_rdata   in  32  word read from the bus
//   st_wdata    in  32  right-justified store data
//   ld_data     out 32  extracted and extended load result
//   st_merged   out 32  bus_rdata with the store lane(s) replaced
module lsu_lane_align
   import quantium_wb_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] bus_rdata,
   input  logic [31:0] st_wdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_merged
);

   logic [7:0]         lane_b;
   logic [15:0]        lane_h;
   logic signed [31:0] ext_b;
   logic signed [31:0] ext_h;

   always_comb begin
      case (addr_lo)
         2'd1:    lane_b = bus_rdata[15:8];
         2'd2:    lane_b = bus_rdata[23:16];
         2'd3:    lane_b = bus_rdata[31:24];
         default: lane_b = bus_rdata[7:0];
      endcase
      lane_h = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      ext_b  = 32'($signed(lane_b));
      ext_h  = 32'($signed(lane_h));

      case (size)
         SZ_B:    ld_data = is_unsigned ? {24'h0, lane_b} : ext_b;
         SZ_H:    ld_data = is_unsigned ? {16'h0, lane_h} : ext_h;
         default: ld_data = bus_rdata;
      endcase

      st_merged = bus_rdata;
      case (size)
         SZ_B: begin
            case (addr_lo)
               2'd1:    st_merged[15:8]  = st_wdata[7:0];
               2'd2:    st_merged[23:16] = st_wdata[7:0];
               2'd3:    st_merged[31:24] = st_wdata[7:0];
               default: st_merged[7:0]   = st_wdata[7:0];
            endcase
         end
         SZ_H: begin
            if (addr_lo[1]) st_merged[31:16] = st_wdata[15:0];
            else            st_merged[15:0]  = st_wdata[15:0];
         end
         default: st_merged = st_wdata;
      endcase
   end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone classic master for the core load/store path. One request at a
// time; sub-word stores are done as read-modify-write on the word bus.
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready while idle)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                  request fields, latched on accept
//   rsp_valid, rsp_rdata,
//   rsp_err                    single-cycle response
//   CYC, STB, WE, ADR, DAT_O,
//   CTI_O                      Wishbone master outputs
//   DAT_I, ACK, ERR, RTY       Wishbone slave returns
module wb_lsu_master
   import quantium_wb_pkg::*;
#(
   parameter int RETRY_MAX = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        CYC,
   output logic        STB,
   output logic        WE,
   output logic [31:0] ADR,
   output logic [31:0] DAT_O,
   output logic [2:0]  CTI_O,
   input  logic [31:0] DAT_I,
   input  logic        ACK,
   input  logic        ERR,
   input  logic        RTY
);

   localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
   localparam logic [WW-1:0] WAIT_LIM  = WW'(TIMEOUT - 1);

   lsu_state_t    state;
   logic          r_we;
   logic          r_uns;
   logic [1:0]    r_size;
   logic [1:0]    r_addr_lo;
   logic [31:0]   r_wdata;
   logic [RW-1:0] retry_cnt;
   logic [WW-1:0] wait_cnt;
   logic [31:0]   ld_data;
   logic [31:0]   st_merged;

   assign req_ready = (state == ST_IDLE);
   assign CTI_O     = CTI_CLASSIC;

   lsu_lane_align u_align (
      .addr_lo     (r_addr_lo),
      .size        (r_size),
      .is_unsigned (r_uns),
      .bus_rdata   (DAT_I),
      .st_wdata    (r_wdata),
      .ld_data     (ld_data),
      .st_merged   (st_merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         CYC       <= 1'b0;
         STB       <= 1'b0;
         WE        <= 1'b0;
         ADR       <= '0;
         DAT_O     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         retry_cnt <= '0;
         wait_cnt  <= '0;
         r_we      <= 1'b0;
         r_uns     <= 1'b0;
         r_size    <= 2'b00;
         r_addr_lo <= 2'b00;
         r_wdata   <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;

         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_we      <= req_we;
                  r_uns     <= req_unsigned;
                  r_size    <= req_size;
                  r_addr_lo <= req_addr[1:0];
                  r_wdata   <= req_wdata;
                  ADR       <= {req_addr[31:2], 2'b00};
                  retry_cnt <= '0;
                  wait_cnt  <= '0;
                  // Refused requests answer on the accept edge itself, so
                  // the pulse is visible in the very next cycle.
                  if (lsu_misaligned(req_size, req_addr[1:0])) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else if (req_we && (req_size == SZ_W)) begin
                     state <= ST_WRITE;
                     CYC   <= 1'b1;
                     STB   <= 1'b1;
                     WE    <= 1'b1;
                     DAT_O <= req_wdata;
                  end else begin
                     // Loads and sub-word stores both start with a read.
                     state <= ST_READ;
                     CYC   <= 1'b1;
                     STB   <= 1'b1;
                     WE    <= 1'b0;
                     DAT_O <= '0;
                  end
               end
            end

            ST_READ, ST_WRITE: begin
               if (!CYC) begin
                  // Idle cycle after RTY has elapsed: reissue the same cycle.
                  CYC      <= 1'b1;
                  STB      <= 1'b1;
                  wait_cnt <= '0;
               end else if (ERR) begin
                  CYC       <= 1'b0;
                  STB       <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  state     <= ST_IDLE;
               end else if (RTY) begin
                  CYC <= 1'b0;
                  STB <= 1'b0;
                  if (retry_cnt == RETRY_LIM) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     retry_cnt <= retry_cnt + RW'(1);
                  end
               end else if (ACK) begin
                  CYC <= 1'b0;
                  STB <= 1'b0;
                  if (state == ST_WRITE) begin
                     rsp_valid <= 1'b1;
                     state     <= ST_IDLE;
                  end else if (r_we) begin
                     DAT_O <= st_merged;
                     state <= ST_GAP;
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= ld_data;
                     state     <= ST_IDLE;
                  end
               end else if (wait_cnt == WAIT_LIM) begin
                  // TIMEOUT cycles with CYC high and no termination.
                  CYC       <= 1'b0;
                  STB       <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end

            ST_GAP: begin
               // Slaves need one idle cycle between the read ACK and the write.
               state     <= ST_WRITE;
               CYC       <= 1'b1;
               STB       <= 1'b1;
               WE        <= 1'b1;
               retry_cnt <= '0;
               wait_cnt  <= '0;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_lsu_master.sv
`timescale 1ns/1ps
module tb_wb_lsu_master;
   import quantium_wb_pkg::*;

   localparam int RETRY_MAX = 4;
   localparam int TIMEOUT   = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        CYC, STB, WE;
   logic [31:0] ADR, DAT_O;
   logic [2:0]  CTI_O;
   logic [31:0] DAT_I = '0;
   logic        ACK = 1'b0;
   logic        ERR = 1'b0;
   logic        RTY = 1'b0;

   always #5 clk = ~clk;

   wb_lsu_master #(.RETRY_MAX(RETRY_MAX), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .CYC          (CYC),
      .STB          (STB),
      .WE           (WE),
      .ADR          (ADR),
      .DAT_O        (DAT_O),
      .CTI_O        (CTI_O),
      .DAT_I        (DAT_I),
      .ACK          (ACK),
      .ERR          (ERR),
      .RTY          (RTY)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Slave behaviour knobs, written only by the stimulus process.
   int rty_cfg    = 0;   // first rty_cfg terminations after term_base are RTY
   bit err_cfg    = 1'b0;
   bit silent_cfg = 1'b0;
   int term_base  = 0;

   // Slave-side observations, written only by the slave process.
   int          n_term = 0, stb_rises = 0, cyc_cycles = 0, wr_count = 0, rsp_count = 0;
   logic        stb_q = 1'b0;
   logic [31:0] last_wadr = '0, last_wdat = '0, last_radr = '0;
   logic [31:0] mem [64];

   // Registered word-addressed slave; DAT_I carries junk except with ACK.
   always @(posedge clk) begin
      ACK   <= 1'b0;
      ERR   <= 1'b0;
      RTY   <= 1'b0;
      DAT_I <= $urandom;
      stb_q <= STB;
      if (STB && !stb_q) stb_rises <= stb_rises + 1;
      if (CYC) cyc_cycles <= cyc_cycles + 1;
      if (rsp_valid) rsp_count <= rsp_count + 1;
      if (CYC && STB && !ACK && !ERR && !RTY && !silent_cfg) begin
         n_term <= n_term + 1;
         if (err_cfg) ERR <= 1'b1;
         else if (n_term - term_base < rty_cfg) RTY <= 1'b1;
         else begin
            ACK <= 1'b1;
            if (WE) begin
               mem[ADR[7:2]] <= DAT_O;
               wr_count      <= wr_count + 1;
               last_wadr     <= ADR;
               last_wdat     <= DAT_O;
            end else begin
               DAT_I     <= mem[ADR[7:2]];
               last_radr <= ADR;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: little-endian lane extraction by shift/mask arithmetic.
   function automatic logic [31:0] model_load(input logic [31:0] w, input int off,
                                              input int nbytes, input bit uns);
      logic [31:0] mask, v;
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
      v = (w >> (8 * off)) & mask;
      if (!uns && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] old, input int off,
                                               input int nbytes, input logic [31:0] d);
      logic [31:0] mask;
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
      return (old & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
   endfunction

   // Issue one request; lat = edges after the accept edge until rsp_valid is seen.
   task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output bit er, output int lat);
      bit got;
      got = 1'b0; lat = -1; rd = '0; er = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      check("req_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int j = 0; j < 200 && !got; j++) begin
         if (rsp_valid) begin
            got = 1'b1; lat = j; rd = rsp_rdata; er = rsp_err;
         end else begin
            @(posedge clk); #1;
         end
      end
      check("rsp_seen", 32'(got), 32'd1);
      if (got) begin
         @(posedge clk); #1;
         check("rsp_pulse", 32'(rsp_valid), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] rd, wd, exp_rd;
      logic [31:0] ref_mem [16];
      bit er, we, uns, bad;
      int lat, b0, w0, c0, r0, sz, nb, addr, idx;
      logic [1:0] szv;

      // Reset values while held in reset.
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cyc", 32'(CYC), 0);
      check("rst_stb", 32'(STB), 0);
      check("rst_we", 32'(WE), 0);
      check("rst_adr", ADR, 0);
      check("rst_dato", DAT_O, 0);
      check("rst_cti", 32'(CTI_O), 0);
      check("rst_rspv", 32'(rsp_valid), 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_rsperr", 32'(rsp_err), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_ready", 32'(req_ready), 1);

      // 1: word store then word load.
      w0 = wr_count; b0 = stb_rises;
      do_req(1, SZ_W, 0, 32'h10, 32'hDEADBEEF, rd, er, lat);
      check("t1_st_err", 32'(er), 0);
      check("t1_st_lat", 32'(lat), 2);
      check("t1_st_nwr", 32'(wr_count - w0), 1);
      check("t1_st_adr", last_wadr, 32'h10);
      check("t1_st_dat", last_wdat, 32'hDEADBEEF);
      check("t1_st_stb", 32'(stb_rises - b0), 1);
      do_req(0, SZ_W, 0, 32'h10, 0, rd, er, lat);
      check("t1_ld_data", rd, 32'hDEADBEEF);
      check("t1_ld_err", 32'(er), 0);
      check("t1_ld_lat", 32'(lat), 2);
      check("t1_ld_adr", last_radr, 32'h10);

      // 2: sub-word loads with both extensions.
      do_req(1, SZ_W, 0, 32'h20, 32'h11223344, rd, er, lat);
      do_req(0, SZ_B, 0, 32'h23, 0, rd, er, lat);
      check("t2_sb23", rd, 32'h00000011);
      check("t2_sb23_adr", last_radr, 32'h20);
      do_req(0, SZ_H, 1, 32'h22, 0, rd, er, lat);
      check("t2_uh22", rd, 32'h00001122);
      do_req(1, SZ_W, 0, 32'h20, 32'h80FF0000, rd, er, lat);
      do_req(0, SZ_H, 0, 32'h22, 0, rd, er, lat);
      check("t2_sh22", rd, 32'hFFFF80FF);
      do_req(0, SZ_B, 0, 32'h22, 0, rd, er, lat);
      check("t2_sb22", rd, 32'hFFFFFFFF);
      do_req(0, SZ_B, 1, 32'h23, 0, rd, er, lat);
      check("t2_ub23", rd, 32'h00000080);

      // 3: byte store read-modify-write.
      do_req(1, SZ_W, 0, 32'h20, 32'h11223344, rd, er, lat);
      w0 = wr_count; b0 = stb_rises;
      do_req(1, SZ_B, 0, 32'h21, 32'h000000AB, rd, er, lat);
      check("t3_lat", 32'(lat), 5);
      check("t3_err", 32'(er), 0);
      check("t3_rdata", rd, 0);
      check("t3_stb", 32'(stb_rises - b0), 2);
      check("t3_nwr", 32'(wr_count - w0), 1);
      check("t3_wadr", last_wadr, 32'h20);
      check("t3_wdat", last_wdat, 32'h1122AB44);

      // 4: retries.
      term_base = n_term; rty_cfg = 2; b0 = stb_rises;
      do_req(0, SZ_W, 0, 32'h10, 0, rd, er, lat);
      check("t4_rty2_err", 32'(er), 0);
      check("t4_rty2_data", rd, 32'hDEADBEEF);
      check("t4_rty2_stb", 32'(stb_rises - b0), 3);
      check("t4_rty2_lat", 32'(lat), 8);
      term_base = n_term; rty_cfg = 1000; b0 = stb_rises;
      do_req(0, SZ_W, 0, 32'h10, 0, rd, er, lat);
      check("t4_rtyx_err", 32'(er), 1);
      check("t4_rtyx_data", rd, 0);
      check("t4_rtyx_stb", 32'(stb_rises - b0), RETRY_MAX + 1);
      rty_cfg = 0;

      // 5: bus error and timeout.
      err_cfg = 1'b1; b0 = stb_rises;
      do_req(0, SZ_W, 0, 32'h10, 0, rd, er, lat);
      check("t5_err_err", 32'(er), 1);
      check("t5_err_data", rd, 0);
      check("t5_err_stb", 32'(stb_rises - b0), 1);
      err_cfg = 1'b0;
      silent_cfg = 1'b1; c0 = cyc_cycles;
      do_req(0, SZ_W, 0, 32'h10, 0, rd, er, lat);
      check("t5_to_err", 32'(er), 1);
      check("t5_to_cyc", 32'(cyc_cycles - c0), TIMEOUT);
      check("t5_to_lat", 32'(lat), TIMEOUT);
      silent_cfg = 1'b0;

      // 6: misaligned and illegal requests.
      b0 = stb_rises;
      do_req(0, SZ_W, 0, 32'h2, 0, rd, er, lat);
      check("t6_w2_err", 32'(er), 1);
      check("t6_w2_lat", 32'(lat), 0);
      do_req(0, SZ_H, 0, 32'h1, 0, rd, er, lat);
      check("t6_h1_err", 32'(er), 1);
      check("t6_h1_data", rd, 0);
      do_req(1, 2'b11, 0, 32'h4, 32'h5, rd, er, lat);
      check("t6_sz3_err", 32'(er), 1);
      check("t6_nocyc", 32'(stb_rises - b0), 0);

      // Random traffic against a word-array model.
      for (int i = 0; i < 16; i++) begin
         wd = $urandom;
         ref_mem[i] = wd;
         do_req(1, SZ_W, 0, 32'(4 * i), wd, rd, er, lat);
      end
      for (int k = 0; k < 150; k++) begin
         sz = $urandom_range(0, 9);
         szv = (sz < 3) ? 2'b00 : (sz < 6) ? 2'b01 : (sz < 9) ? 2'b10 : 2'b11;
         nb = (szv == 2'b00) ? 1 : (szv == 2'b01) ? 2 : 4;
         addr = $urandom_range(0, 63);
         idx = addr / 4;
         we = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         wd = $urandom;
         bad = (szv == 2'b11) || (addr % nb != 0);
         term_base = n_term; rty_cfg = $urandom_range(0, 2);
         do_req(we, szv, uns, 32'(addr), wd, rd, er, lat);
         exp_rd = 0;
         if (!bad && !we) exp_rd = model_load(ref_mem[idx], addr % 4, nb, uns);
         if (!bad && we) ref_mem[idx] = model_store(ref_mem[idx], addr % 4, nb, wd);
         check("rnd_err", 32'(er), 32'(bad));
         check("rnd_rdata", rd, exp_rd);
      end
      rty_cfg = 0;
      for (int i = 0; i < 16; i++) begin
         do_req(0, SZ_W, 0, 32'(4 * i), 0, rd, er, lat);
         check("rnd_readback", rd, ref_mem[i]);
      end

      // Reset in the middle of a read: bus released at once, no response.
      silent_cfg = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_addr = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("mid_cyc_on", 32'(CYC), 1);
      check("mid_cti", 32'(CTI_O), 0);
      r0 = rsp_count;
      #2 rst_n = 1'b0;
      #1;
      check("mid_cyc_off", 32'(CYC), 0);
      check("mid_stb_off", 32'(STB), 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      silent_cfg = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_no_rsp", 32'(rsp_count - r0), 0);
      check("mid_ready", 32'(req_ready), 1);
      do_req(0, SZ_W, 0, 32'h10, 0, rd, er, lat);
      check("mid_after_ld", rd, ref_mem[4]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
